// File: rtl/booth_seq_mult_pkg.sv
// Shared definitions for the radix-2 Booth sequential multiplier:
// controller state encoding and iteration counter sizing.
package booth_seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_e;

   // Wide enough to hold the value N itself, not just N-1.
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/booth_seq_mult_add_sub.sv
// N-bit signed adder/subtractor with an N+1-bit sign-extended result,
// so that A - M never loses its sign even when M is the most negative value.
module Nbit_add_sub #(
   parameter int N = 4
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         k_i,
   output logic [N:0]   s_o
);

   logic [N:0] a_ext_s;
   logic [N:0] b_ext_s;

   assign a_ext_s = {a_i[N-1], a_i};
   assign b_ext_s = {b_i[N-1], b_i};

   // k_i selects subtraction, otherwise addition
   always_comb begin
      if (k_i) begin
         s_o = a_ext_s - b_ext_s;
      end else begin
         s_o = a_ext_s + b_ext_s;
      end
   end

endmodule

// File: rtl/booth_seq_mult.sv
// Radix-2 Booth sequential signed multiplier: one shared add/sub step per
// cycle for N cycles, then a one-cycle done pulse with the 2N-bit product.
module booth_seq_mult
   import booth_seq_mult_pkg::*;
#(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   multiplicand,
   input  logic [N-1:0]   multiplier,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);

   localparam int CW = cnt_width(N);

   state_e          state_q, state_d;
   logic [N-1:0]    a_q, a_d;
   logic [N-1:0]    q_q, q_d;
   logic            qm1_q, qm1_d;
   logic [N-1:0]    m_q, m_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [2*N-1:0]  product_q, product_d;

   logic [1:0]      op_s;
   logic            k_s;
   logic [N:0]      add_s;
   logic [N:0]      res_s;

   assign op_s = {q_q[0], qm1_q};
   assign k_s  = (op_s == 2'b10);

   Nbit_add_sub #(.N(N)) u_add_sub (
      .a_i (a_q),
      .b_i (m_q),
      .k_i (k_s),
      .s_o (add_s)
   );

   // Bit pairs 00/11 bypass the adder and shift the sign-extended accumulator
   always_comb begin
      if (op_s[1] ^ op_s[0]) begin
         res_s = add_s;
      end else begin
         res_s = {a_q[N-1], a_q};
      end
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      q_d       = q_q;
      qm1_d     = qm1_q;
      m_d       = m_q;
      cnt_d     = cnt_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      product_d = product_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               m_d     = multiplicand;
               q_d     = multiplier;
               a_d     = '0;
               qm1_d   = 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            a_d   = res_s[N:1];
            q_d   = {res_s[0], q_q[N-1:1]};
            qm1_d = q_q[0];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
               state_d   = DONE;
               done_d    = 1'b1;
               product_d = {res_s[N:1], res_s[0], q_q[N-1:1]};
            end else begin
               busy_d    = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_q       <= '0;
         q_q       <= '0;
         qm1_q     <= 1'b0;
         m_q       <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         q_q       <= q_d;
         qm1_q     <= qm1_d;
         m_q       <= m_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         product_q <= product_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and swept checks of booth_seq_mult at N=4 and N=8.
module tb_booth_seq_mult;

   logic        clk;
   logic        rst_n;
   logic        start4, start8;
   logic [3:0]  m4, q4;
   logic [7:0]  m8, q8;
   logic        busy4, done4, busy8, done8;
   logic [7:0]  prod4;
   logic [15:0] prod8;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   booth_seq_mult #(.N(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4),
      .multiplicand(m4), .multiplier(q4),
      .busy(busy4), .done(done4), .product(prod4)
   );

   booth_seq_mult #(.N(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8),
      .multiplicand(m8), .multiplier(q8),
      .busy(busy8), .done(done8), .product(prod8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle label: the cycle following edge e carries label e+1
   always @(posedge clk) cyc <= cyc + 1;

   // Called at a sample point; returns at the sample point after the done pulse.
   task automatic do_mult4(input logic [3:0] m, input logic [3:0] q,
                           output logic [7:0] p, output int lat,
                           output int bcnt, output int dw);
      int  t;
      bit  seen;
      p = 8'h00; lat = -1; bcnt = 0; dw = 0; seen = 1'b0;
      m4 = m; q4 = q; start4 = 1'b1;
      @(posedge clk); #1;
      t = cyc - 1;
      start4 = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (busy4) bcnt++;
         if (done4) begin
            seen = 1'b1; p = prod4; lat = cyc - t;
         end else begin
            @(posedge clk); #1;
         end
      end
      while (seen && done4 && dw < 5) begin
         dw++;
         @(posedge clk); #1;
      end
   endtask

   task automatic do_mult8(input logic [7:0] m, input logic [7:0] q,
                           output logic [15:0] p, output int lat, output int dw);
      int  t;
      bit  seen;
      p = 16'h0000; lat = -1; dw = 0; seen = 1'b0;
      m8 = m; q8 = q; start8 = 1'b1;
      @(posedge clk); #1;
      t = cyc - 1;
      start8 = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         if (done8) begin
            seen = 1'b1; p = prod8; lat = cyc - t;
         end else begin
            @(posedge clk); #1;
         end
      end
      while (seen && done8 && dw < 5) begin
         dw++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start4 = 1'b0; start8 = 1'b0;
      m4 = 4'h0; q4 = 4'h0; m8 = 8'h00; q8 = 8'h00;
      #12;
      checks++;
      if ({busy4, done4, prod4} !== 10'h000) begin
         errors++;
         $display("FAIL reset_n4: busy=%b done=%b product=%h, required 0 0 00", busy4, done4, prod4);
      end
      checks++;
      if ({busy8, done8, prod8} !== 18'h00000) begin
         errors++;
         $display("FAIL reset_n8: busy=%b done=%b product=%h, required 0 0 0000", busy8, done8, prod8);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [3:0] m;
      logic [3:0] q;
      logic [7:0] exp;
   } vec_t;

   task automatic test_directed();
      vec_t       vecs [6];
      logic [7:0] p;
      int         lat, bcnt, dw;
      vecs[0] = '{4'h3, 4'hE, 8'hFA};
      vecs[1] = '{4'h8, 4'h8, 8'h40};
      vecs[2] = '{4'h8, 4'h7, 8'hC8};
      vecs[3] = '{4'h7, 4'h7, 8'h31};
      vecs[4] = '{4'h0, 4'hB, 8'h00};
      vecs[5] = '{4'hF, 4'hF, 8'h01};
      for (int i = 0; i < 6; i++) begin
         do_mult4(vecs[i].m, vecs[i].q, p, lat, bcnt, dw);
         checks++;
         if (p !== vecs[i].exp) begin
            errors++;
            $display("FAIL directed_product[%0d]: got %h, required %h", i, p, vecs[i].exp);
         end
         checks++;
         if (lat !== 5) begin
            errors++;
            $display("FAIL directed_latency[%0d]: got %0d, required 5", i, lat);
         end
         checks++;
         if (bcnt !== 4) begin
            errors++;
            $display("FAIL directed_busy_cycles[%0d]: got %0d, required 4", i, bcnt);
         end
         checks++;
         if (dw !== 1) begin
            errors++;
            $display("FAIL directed_done_width[%0d]: got %0d, required 1", i, dw);
         end
      end
   endtask

   task automatic test_ignore_start();
      int         dones;
      logic [7:0] p;
      dones = 0; p = 8'h00;
      m4 = 4'h3; q4 = 4'hE; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      @(posedge clk); #1;
      start4 = 1'b1; m4 = 4'h5; q4 = 4'h5;
      @(posedge clk); #1;
      start4 = 1'b0; m4 = 4'h9; q4 = 4'h2;
      for (int i = 0; i < 12; i++) begin
         if (done4) begin
            dones++; p = prod4;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (dones !== 1) begin
         errors++;
         $display("FAIL ignore_start_done_count: got %0d, required 1", dones);
      end
      checks++;
      if (p !== 8'hFA) begin
         errors++;
         $display("FAIL ignore_start_product: got %h, required fa", p);
      end
   endtask

   task automatic test_back_to_back();
      int         dcyc [3];
      logic [7:0] dp   [3];
      int         n;
      n = 0;
      m4 = 4'h2; q4 = 4'h3; start4 = 1'b1;
      for (int i = 0; i < 40 && n < 3; i++) begin
         @(posedge clk); #1;
         if (done4) begin
            dcyc[n] = cyc; dp[n] = prod4; n++;
         end
      end
      start4 = 1'b0;
      checks++;
      if (n !== 3) begin
         errors++;
         $display("FAIL b2b_result_count: got %0d, required 3", n);
      end
      for (int i = 0; i < n; i++) begin
         checks++;
         if (dp[i] !== 8'h06) begin
            errors++;
            $display("FAIL b2b_product[%0d]: got %h, required 06", i, dp[i]);
         end
      end
      for (int i = 1; i < n; i++) begin
         checks++;
         if (dcyc[i] - dcyc[i-1] !== 6) begin
            errors++;
            $display("FAIL b2b_spacing[%0d]: got %0d, required 6", i, dcyc[i] - dcyc[i-1]);
         end
      end
      repeat (3) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_async_reset();
      int         dones;
      logic [7:0] p;
      int         lat, bcnt, dw;
      dones = 0;
      m4 = 4'h3; q4 = 4'hE; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy4, done4, prod4} !== 10'h000) begin
         errors++;
         $display("FAIL async_reset_outputs: busy=%b done=%b product=%h, required 0 0 00", busy4, done4, prod4);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (done4) dones++;
         @(posedge clk); #1;
      end
      checks++;
      if (dones !== 0) begin
         errors++;
         $display("FAIL async_reset_no_done: got %0d done pulses, required 0", dones);
      end
      do_mult4(4'h3, 4'hE, p, lat, bcnt, dw);
      checks++;
      if (p !== 8'hFA) begin
         errors++;
         $display("FAIL async_reset_recovery: got %h, required fa", p);
      end
   endtask

   task automatic test_sweep4();
      logic [7:0]        p;
      logic signed [7:0] ref_p;
      int                lat, bcnt, dw;
      for (int i = 0; i < 256; i++) begin
         logic [3:0] m, q;
         m = 4'(i >> 4);
         q = 4'(i);
         ref_p = $signed(m) * $signed(q);
         do_mult4(m, q, p, lat, bcnt, dw);
         checks++;
         if (p !== ref_p || dw !== 1) begin
            errors++;
            $display("FAIL sweep4 m=%h q=%h: product %h width %0d, required %h width 1", m, q, p, dw, ref_p);
         end
      end
   endtask

   task automatic test_sweep8();
      logic [15:0]        p;
      logic signed [15:0] ref_p;
      int                 lat, dw;
      for (int i = 0; i < 1000; i++) begin
         logic [7:0] m, q;
         m = 8'($urandom_range(0, 255));
         q = 8'($urandom_range(0, 255));
         if (i == 0) begin
            m = 8'h80; q = 8'h80;
         end
         ref_p = $signed(m) * $signed(q);
         do_mult8(m, q, p, lat, dw);
         checks++;
         if (p !== ref_p || dw !== 1 || lat !== 9) begin
            errors++;
            $display("FAIL sweep8 m=%h q=%h: product %h width %0d latency %0d, required %h width 1 latency 9",
                     m, q, p, dw, lat, ref_p);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_back_to_back();
      test_async_reset();
      test_sweep4();
      test_sweep8();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
